// File: rtl/pr_pkg.sv
// Shared definitions for the PageRank engine sequencer.
// Holds the default engine geometry and the sequencer state encoding.
package pr_pkg;

  localparam int PR_N        = 64;  // graph nodes
  localparam int PR_LANES    = 4;   // nodes issued per beat
  localparam int PR_MAX_ITER = 40;  // rank-update passes
  localparam int PR_ID_W     = 6;   // node index width, clog2(PR_N)
  localparam int PR_IT_W     = 6;   // pass counter width, 2^PR_IT_W > PR_MAX_ITER

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    SORT,
    HOLD
  } pr_seq_state_t;

endpackage

// File: rtl/pr_batch_counter.sv
// Wrap-at-limit stride counter.
// Counts 0, STEP, 2*STEP, ... LIMIT and wraps back to 0 on the next enable.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance by STEP (or wrap when at LIMIT)
//   cnt        : current count
//   last       : cnt equals LIMIT
module pr_batch_counter #(
  parameter int W     = 6,
  parameter int STEP  = 1,
  parameter int LIMIT = 63
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] STEP_V  = W'(STEP);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  assign last = (cnt == LIMIT_V);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + STEP_V;
    end
  end

endmodule

// File: rtl/pr_iter_sequencer.sv
// Top-level sequencer of the PageRank engine.
// Runs MAX_ITER passes over all N nodes (LANES nodes per beat) through the
// rank-update datapath, then launches the top-10 sorter and holds the result
// until the host acknowledges it.
//
// Build option: CONV_EXIT_EN -- when defined, a converged flag presented with
// wb_done (from pass 1 onward) ends the iteration early and starts the sorter.
// When undefined the converged input is ignored and all passes always run.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start          : host start request, only honoured in IDLE
//   busy           : high in every state except IDLE
//   batch_valid/ready/base : batch offer to the datapath (base..base+LANES-1)
//   iter_idx       : current pass number
//   wb_done        : pass write-back complete pulse
//   converged      : convergence flag (CONV_EXIT_EN builds only)
//   sort_start     : one-cycle sorter launch pulse
//   sort_done      : sorter finished (level or pulse)
//   result_valid   : sorter outputs stable, held until result_ack
//   result_ack     : host consumed the result
//   err            : sticky protocol error, cleared by an accepted start
module pr_iter_sequencer
  import pr_pkg::*;
#(
  parameter int N        = PR_N,
  parameter int LANES    = PR_LANES,
  parameter int MAX_ITER = PR_MAX_ITER,
  parameter int ID_W     = PR_ID_W,
  parameter int IT_W     = PR_IT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            batch_valid,
  input  logic            batch_ready,
  output logic [ID_W-1:0] batch_base,
  output logic [IT_W-1:0] iter_idx,
  input  logic            wb_done,
  input  logic            converged,
  output logic            sort_start,
  input  logic            sort_done,
  output logic            result_valid,
  input  logic            result_ack,
  output logic            err
);

  pr_seq_state_t state;

  logic start_acc;
  logic beat;
  logic node_last;
  logic iter_last;
  logic iter_en;
  logic conv_exit;

  assign start_acc = (state == IDLE) && start;
  assign beat      = (state == ISSUE) && batch_valid && batch_ready;

`ifdef CONV_EXIT_EN
  // Early exit needs at least one completed pass before convergence counts.
  assign conv_exit = converged && (iter_idx != '0);
`else
  logic unused_converged;
  assign unused_converged = converged;
  assign conv_exit        = 1'b0;
`endif

  // The pass counter freezes on the final pass (or an early exit) so the
  // host can read the number of the last completed pass.
  assign iter_en = (state == DRAIN) && wb_done && !iter_last && !conv_exit;

  pr_batch_counter #(
    .W     (ID_W),
    .STEP  (LANES),
    .LIMIT (N - LANES)
  ) u_node_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .en    (beat),
    .cnt   (batch_base),
    .last  (node_last)
  );

  pr_batch_counter #(
    .W     (IT_W),
    .STEP  (1),
    .LIMIT (MAX_ITER - 1)
  ) u_iter_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .en    (iter_en),
    .cnt   (iter_idx),
    .last  (iter_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      batch_valid  <= 1'b0;
      sort_start   <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      sort_start <= 1'b0;

      // Stray pulses only flag the error; they never steer the state machine.
      if (wb_done && (state != DRAIN)) begin
        err <= 1'b1;
      end
      if (sort_done && (state != SORT) && (state != HOLD)) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            batch_valid <= 1'b1;
            err         <= 1'b0;
          end
        end
        ISSUE: begin
          // batch_valid stays high across beats; only the final beat drops it.
          if (beat && node_last) begin
            state       <= DRAIN;
            batch_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (wb_done) begin
            if (iter_last || conv_exit) begin
              state      <= SORT;
              sort_start <= 1'b1;
            end else begin
              state       <= ISSUE;
              batch_valid <= 1'b1;
            end
          end
        end
        SORT: begin
          if (sort_done) begin
            state        <= HOLD;
            result_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ack) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          batch_valid  <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
